// File: rtl/pattern_det_sched.sv
// Round-robin scheduler that shares one bit-serial 10110 detector between two
// byte-packet requesters and attributes detector hits to the owning requester.
module pattern_det_sched #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              det_rst,
  output logic              det_valid,
  output logic              det_data,
  input  logic              det_hit,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  hit_cnt0,
  output logic [CNT_W-1:0]  hit_cnt1,
  output logic              pkt_done
);

  localparam int unsigned       BC_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_n;
  logic [1:0]        r_grant, w_grant_n;
  logic              r_ptr, w_ptr_n;
  logic              r_rdy0, w_rdy0_n;
  logic              r_rdy1, w_rdy1_n;
  logic              r_det_rst, w_det_rst_n;
  logic              r_det_valid, w_det_valid_n;
  logic              r_pkt_done, w_pkt_done_n;
  logic [DATA_W-1:0] r_shreg, w_shreg_n;
  logic [BC_W-1:0]   r_bit_cnt, w_bit_cnt_n;
  logic              r_last, w_last_n;

  logic              r_det_valid_d;
  logic              r_owner_d;
  logic [CNT_W-1:0]  r_hit_cnt0, r_hit_cnt1;

  logic              w_hs;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  // Handshake and payload of whichever channel currently owns the detector
  assign w_hs       = (r_grant[0] & req0_valid & r_rdy0) | (r_grant[1] & req1_valid & r_rdy1);
  assign w_sel_data = r_grant[1] ? req1_data : req0_data;
  assign w_sel_last = r_grant[1] ? req1_last : req0_last;

  always_comb begin
    w_state_n     = r_state;
    w_grant_n     = r_grant;
    w_ptr_n       = r_ptr;
    w_rdy0_n      = 1'b0;
    w_rdy1_n      = 1'b0;
    w_det_rst_n   = 1'b0;
    w_det_valid_n = 1'b0;
    w_pkt_done_n  = 1'b0;
    w_shreg_n     = r_shreg;
    w_bit_cnt_n   = r_bit_cnt;
    w_last_n      = r_last;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && (!req1_valid || !r_ptr)) begin
          w_grant_n   = 2'b01;
          w_state_n   = S_CLEAR;
          w_det_rst_n = 1'b1;
        end else if (req1_valid) begin
          w_grant_n   = 2'b10;
          w_state_n   = S_CLEAR;
          w_det_rst_n = 1'b1;
        end
      end
      S_CLEAR: begin
        w_state_n = S_LOAD;
        w_rdy0_n  = r_grant[0];
        w_rdy1_n  = r_grant[1];
      end
      S_LOAD: begin
        if (w_hs) begin
          w_shreg_n     = w_sel_data;
          w_last_n      = w_sel_last;
          w_bit_cnt_n   = '0;
          w_det_valid_n = 1'b1;
          w_state_n     = S_SHIFT;
        end else begin
          w_rdy0_n = r_grant[0];
          w_rdy1_n = r_grant[1];
        end
      end
      S_SHIFT: begin
        w_shreg_n   = {r_shreg[DATA_W-2:0], 1'b0};
        w_bit_cnt_n = r_bit_cnt + BC_W'(1);
        if (r_bit_cnt == LAST_BIT) begin
          if (r_last) begin
            w_state_n    = S_DONE;
            w_pkt_done_n = 1'b1;
          end else begin
            w_state_n = S_LOAD;
            w_rdy0_n  = r_grant[0];
            w_rdy1_n  = r_grant[1];
          end
        end else begin
          w_det_valid_n = 1'b1;
        end
      end
      S_DONE: begin
        // Channel just served loses the next tie
        w_ptr_n   = r_grant[0];
        w_grant_n = 2'b00;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'b00;
      r_ptr       <= 1'b0;
      r_rdy0      <= 1'b0;
      r_rdy1      <= 1'b0;
      r_det_rst   <= 1'b0;
      r_det_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_grant     <= w_grant_n;
      r_ptr       <= w_ptr_n;
      r_rdy0      <= w_rdy0_n;
      r_rdy1      <= w_rdy1_n;
      r_det_rst   <= w_det_rst_n;
      r_det_valid <= w_det_valid_n;
      r_pkt_done  <= w_pkt_done_n;
      r_shreg     <= w_shreg_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_last      <= w_last_n;
    end
  end

  // Detector output lags its input by one cycle, so attribute using delayed valid/owner
  always_ff @(posedge clk) begin
    if (rst) begin
      r_det_valid_d <= 1'b0;
      r_owner_d     <= 1'b0;
      r_hit_cnt0    <= '0;
      r_hit_cnt1    <= '0;
    end else begin
      r_det_valid_d <= r_det_valid;
      r_owner_d     <= r_grant[1];
      if (det_hit && r_det_valid_d) begin
        if (!r_owner_d && (r_hit_cnt0 != CNT_MAX)) r_hit_cnt0 <= r_hit_cnt0 + CNT_W'(1);
        if (r_owner_d && (r_hit_cnt1 != CNT_MAX))  r_hit_cnt1 <= r_hit_cnt1 + CNT_W'(1);
      end
    end
  end

  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign det_rst    = r_det_rst;
  assign det_valid  = r_det_valid;
  assign det_data   = r_shreg[DATA_W-1];
  assign grant      = r_grant;
  assign hit_cnt0   = r_hit_cnt0;
  assign hit_cnt1   = r_hit_cnt1;
  assign pkt_done   = r_pkt_done;

endmodule
